// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: forward key expansion to K10, then ten inverse
// rounds at one per cycle while the key schedule is unwound on the fly.
module aes_decrypt_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(9);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_ROUND, S_DONE} state_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
  endfunction

  // Byte i sits at bits [127-8i -: 8]; i = row + 4*col.
  function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[BLK_W-1-8*(r+4*c) -: 8] = s[BLK_W-1-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] inv_sub_bytes(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[BLK_W-1-8*i -: 8] = inv_sbox(s[BLK_W-1-8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [WORD_W-1:0] inv_mix_col(input logic [WORD_W-1:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      a[r]   = col[WORD_W-1-8*r -: 8];
      x2     = xtime(a[r]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m9[r]  = x8 ^ a[r];
      m11[r] = x8 ^ x2 ^ a[r];
      m13[r] = x8 ^ x4 ^ a[r];
      m14[r] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[BLK_W-1-WORD_W*c -: WORD_W] = inv_mix_col(s[BLK_W-1-WORD_W*c -: WORD_W]);
    end
    return o;
  endfunction

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   st_q, st_d, ct_q, ct_d, rk_q, rk_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, out_valid_q;

  logic [WORD_W-1:0]  w0, w1, w2, w3;
  logic [WORD_W-1:0]  f0, f1, f2, f3;
  logic [WORD_W-1:0]  p0, p1, p2, p3;
  logic [WORD_W-1:0]  sw_in, sw_out;
  logic [BLK_W-1:0]   fwd_key, prev_key, inv_core;

  // Key schedule step, forward in EXPAND and reversed in ROUND, sharing one SubWord.
  always_comb begin
    w0 = rk_q[127:96];
    w1 = rk_q[95:64];
    w2 = rk_q[63:32];
    w3 = rk_q[31:0];
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    sw_in  = (state_q == S_ROUND) ? rot_word(p3) : rot_word(w3);
    sw_out = sub_word(sw_in);
    f0 = w0 ^ sw_out ^ {rcon_q, 24'h0};
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    f3 = w3 ^ f2;
    p0 = w0 ^ sw_out ^ {rcon_q, 24'h0};
    fwd_key  = {f0, f1, f2, f3};
    prev_key = {p0, p1, p2, p3};
    inv_core = inv_sub_bytes(inv_shift_rows(st_q)) ^ prev_key;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      st_q        <= '0;
      ct_q        <= '0;
      rk_q        <= '0;
      rcon_q      <= 8'h01;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      ct_q        <= ct_d;
      rk_q        <= rk_d;
      rcon_q      <= rcon_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (in_valid) state_d = S_EXPAND;
      S_EXPAND: if (cnt_q == LAST_STEP) state_d = S_ROUND;
      S_ROUND:  if (cnt_q == LAST_STEP) state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath register updates per state.
  always_comb begin
    st_d   = st_q;
    ct_d   = ct_q;
    rk_d   = rk_q;
    rcon_d = rcon_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ct_d   = data_in;
          rk_d   = key;
          rcon_d = 8'h01;
          cnt_d  = '0;
        end
      end
      S_EXPAND: begin
        rk_d   = fwd_key;
        rcon_d = xtime(rcon_q);
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          // Hold rcon at 0x36: the first inverse step needs the last forward constant.
          st_d   = ct_q ^ fwd_key;
          rcon_d = rcon_q;
          cnt_d  = '0;
        end
      end
      S_ROUND: begin
        rk_d   = prev_key;
        rcon_d = inv_xtime(rcon_q);
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          st_d  = inv_core;
          cnt_d = '0;
        end else begin
          st_d = inv_mix_columns(inv_core);
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = st_q;

endmodule
